// File: rtl/dff_pipe.sv
// dff_pipe: elastic register pipeline of DEPTH stages, SZE bits each, valid/ready handshake.
// Latency: DEPTH edges from capture to out_valid (empty pipe, out_ready=1); one word/cycle throughput.
// Backpressure: combinational ready chain, so a stage accepts whenever it or any stage downstream
//   can move; a full pipe with out_ready=0 deasserts in_ready and every stage holds.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   flush           synchronous clear of all valid bits (data registers keep their contents)
//   in_valid/in_ready/data    upstream handshake and word
//   out_valid/out_ready/q     downstream handshake; q is the last stage's data register
//   qnot            ~q
//   occ             occupancy; a live counter only when DFF_PIPE_OCC_EN is defined, else 0
//
// Optional feature macro: DFF_PIPE_OCC_EN (occupancy counter on occ).

module dff_pipe #(
  parameter int             SZE     = 4,
  parameter int             DEPTH   = 3,
  parameter logic [SZE-1:0] RST_VAL = {SZE{1'b1}}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SZE-1:0]             data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SZE-1:0]             q,
  output logic [SZE-1:0]             qnot,
  output logic [$clog2(DEPTH+1)-1:0] occ
);

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] rdy;
  logic [SZE-1:0]   dat [DEPTH];
  logic             chain;
  logic             in_fire;

  // Stage i is ready if it is empty or everything downstream of it can move.
  // Built as a running OR from the output side so no bit of rdy feeds another.
  always_comb begin
    rdy   = '0;
    chain = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      chain  = chain | ~vld[i];
      rdy[i] = chain;
    end
  end

  // flush blocks both handshakes for its cycle, so nothing is accepted or emitted.
  assign in_ready  = rdy[0] & ~flush;
  assign in_fire   = in_valid & in_ready;
  assign out_valid = vld[DEPTH-1] & ~flush;
  assign q         = dat[DEPTH-1];
  assign qnot      = ~q;

  // Data registers only load on a valid word, so q keeps the last delivered word
  // (or RST_VAL) while the pipe is empty or flushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat[i] <= RST_VAL;
      end
    end else if (flush) begin
      vld <= '0;
    end else begin
      if (rdy[0]) begin
        vld[0] <= in_fire;
        if (in_fire) begin
          dat[0] <= data;
        end
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (rdy[i]) begin
          vld[i] <= vld[i-1];
          if (vld[i-1]) begin
            dat[i] <= dat[i-1];
          end
        end
      end
    end
  end

`ifdef DFF_PIPE_OCC_EN
  localparam int OCW = $clog2(DEPTH + 1);

  logic           out_fire;
  logic [OCW-1:0] occ_r;

  assign out_fire = out_valid & out_ready;

  // Tracks popcount(vld): accept and emit in the same cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_r <= '0;
    end else if (flush) begin
      occ_r <= '0;
    end else begin
      occ_r <= occ_r + OCW'(in_fire) - OCW'(out_fire);
    end
  end

  assign occ = occ_r;
`else
  assign occ = '0;
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: directed bench for dff_pipe.
// Instance u0: SZE=4, DEPTH=3, RST_VAL=4'hF.  Instance u1: SZE=4, DEPTH=1.
// Expected occupancy is the hand-computed count when the counter is built, else 0.

`ifdef DFF_PIPE_OCC_EN
`define TB_EXP_OCC(n) (n)
`else
`define TB_EXP_OCC(n) 0
`endif

module tb_dff_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  // DEPTH=3 instance
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] data = 4'h0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] q;
  logic [3:0] qnot;
  logic [1:0] occ;

  // DEPTH=1 instance
  logic       s_flush = 1'b0;
  logic       s_in_valid = 1'b0;
  logic       s_in_ready;
  logic [3:0] s_data = 4'h0;
  logic       s_out_valid;
  logic       s_out_ready = 1'b0;
  logic [3:0] s_q;
  logic [3:0] s_qnot;
  logic [0:0] s_occ;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dff_pipe #(.SZE(4), .DEPTH(3), .RST_VAL(4'hF)) u0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .data(data),
    .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .qnot(qnot), .occ(occ)
  );

  dff_pipe #(.SZE(4), .DEPTH(1), .RST_VAL(4'hF)) u1 (
    .clk(clk), .rst(rst), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .data(s_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .q(s_q), .qnot(s_qnot), .occ(s_occ)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] qe);
    logic [3:0] qn;
    qn = ~qe;
    chk({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, v});
    chk({tag, ".q"}, {28'b0, q}, {28'b0, qe});
    chk({tag, ".qnot"}, {28'b0, qnot}, {28'b0, qn});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    logic       ev;
    logic [3:0] eq;
    int         ecnt;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    chk_out("rst", 1'b0, 4'hF);
    chk("rst.occ", occ, `TB_EXP_OCC(0));
    rst = 1'b0;
    #1;
    chk("rst.in_ready", in_ready, 1);
    tick();

    // ---------------- streaming 1..5, out_ready=1 ----------------
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 5);
      data     = 4'(c + 1);
      #1;
      ev   = (c >= 3 && c <= 7);
      eq   = (c < 3) ? 4'hF : ((c <= 7) ? 4'(c - 2) : 4'h5);
      ecnt = ((c < 5) ? c : 5) - ((c < 3) ? 0 : ((c - 3 > 5) ? 5 : c - 3));
      chk($sformatf("stream%0d.in_ready", c), in_ready, 1);
      chk_out($sformatf("stream%0d", c), ev, eq);
      chk($sformatf("stream%0d.occ", c), occ, `TB_EXP_OCC(ecnt));
      tick();
    end
    in_valid = 1'b0;

    // ---------------- backpressure: fill until in_ready drops ----------------
    out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      data     = 4'(6 + acc);
      #1;
      if (!in_ready) break;
      acc++;
      tick();
    end
    chk("bp.accepted", acc, 3);
    chk("bp.full.in_ready", in_ready, 0);
    chk("bp.full.occ", occ, `TB_EXP_OCC(3));
    chk_out("bp.full", 1'b1, 4'h6);
    // 4th word (9) offered while out_ready rises
    out_ready = 1'b1;
    #1;
    chk("bp.rise.in_ready", in_ready, 1);
    chk_out("bp.rise", 1'b1, 4'h6);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk_out($sformatf("bp.drain%0d", k), 1'b1, 4'(7 + k));
      chk($sformatf("bp.drain%0d.occ", k), occ, `TB_EXP_OCC(3 - k));
      tick();
    end
    #1;
    chk_out("bp.empty", 1'b0, 4'h9);
    chk("bp.empty.occ", occ, `TB_EXP_OCC(0));

    // ---------------- bubble compression: A, idle, B with out_ready=0 ----------------
    out_ready = 1'b0;
    in_valid = 1'b1; data = 4'hA; tick();
    in_valid = 1'b0;              tick();
    in_valid = 1'b1; data = 4'hB; tick();
    in_valid = 1'b0;              tick();
    #1;
    chk("bubble.vld", u0.vld, 3'b110);
    chk("bubble.stage1", u0.dat[1], 4'hB);
    chk("bubble.occ", occ, `TB_EXP_OCC(2));
    chk_out("bubble.hold", 1'b1, 4'hA);
    out_ready = 1'b1;
    tick();
    #1;
    chk_out("bubble.second", 1'b1, 4'hB);
    tick();
    #1;
    chk_out("bubble.done", 1'b0, 4'hB);
    chk("bubble.done.occ", occ, `TB_EXP_OCC(0));

    // ---------------- flush with 3 valid words ----------------
    out_ready = 1'b0;
    in_valid = 1'b1;
    data = 4'hC; tick();
    data = 4'hD; tick();
    data = 4'hE; tick();
    in_valid = 1'b0;
    #1;
    chk_out("flush.pre", 1'b1, 4'hC);
    chk("flush.pre.occ", occ, `TB_EXP_OCC(3));
    flush = 1'b1; in_valid = 1'b1; data = 4'h1; out_ready = 1'b1;
    #1;
    chk("flush.in_ready", in_ready, 0);
    chk("flush.out_valid", out_valid, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk_out("flush.post", 1'b0, 4'hC);
    chk("flush.post.occ", occ, `TB_EXP_OCC(0));
    chk("flush.post.vld", u0.vld, 3'b000);
    tick();
    #1;
    chk_out("flush.idle", 1'b0, 4'hC);

    // ---------------- asynchronous reset mid-stream ----------------
    out_ready = 1'b1;
    in_valid = 1'b1;
    data = 4'h3; tick();
    data = 4'h4; tick();
    data = 4'h5; tick();
    #1;
    chk_out("midrst.pre", 1'b1, 4'h3);
    rst = 1'b1;
    #1;
    chk_out("midrst.async", 1'b0, 4'hF);
    chk("midrst.occ", occ, `TB_EXP_OCC(0));
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst.in_ready", in_ready, 1);
    chk_out("midrst.after", 1'b0, 4'hF);

    // ---------------- DEPTH=1 single-entry behaviour ----------------
    chk("d1.rst.out_valid", s_out_valid, 0);
    chk("d1.rst.q", s_q, 4'hF);
    chk("d1.rst.in_ready", s_in_ready, 1);
    s_in_valid = 1'b1; s_data = 4'h1;
    #1;
    chk("d1.empty.in_ready", s_in_ready, 1);
    tick();
    s_data = 4'h2;
    #1;
    chk("d1.full.out_valid", s_out_valid, 1);
    chk("d1.full.q", s_q, 4'h1);
    chk("d1.full.qnot", s_qnot, 4'hE);
    chk("d1.full.in_ready", s_in_ready, 0);
    chk("d1.full.occ", s_occ, `TB_EXP_OCC(1));
    tick();
    #1;
    chk("d1.hold.q", s_q, 4'h1);
    s_out_ready = 1'b1;
    #1;
    chk("d1.pass.in_ready", s_in_ready, 1);
    tick();
    s_in_valid = 1'b0; s_out_ready = 1'b0;
    #1;
    chk("d1.swap.out_valid", s_out_valid, 1);
    chk("d1.swap.q", s_q, 4'h2);
    chk("d1.swap.in_ready", s_in_ready, 0);
    tick();
    #1;
    chk("d1.stall.q", s_q, 4'h2);
    s_out_ready = 1'b1;
    tick();
    #1;
    chk("d1.drain.out_valid", s_out_valid, 0);
    chk("d1.drain.q", s_q, 4'h2);
    chk("d1.drain.qnot", s_qnot, 4'hD);
    chk("d1.drain.occ", s_occ, `TB_EXP_OCC(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
